pipe_buffer: RTL

PIPE_BUFFER -- requirements
Module: pipe_buffer

---
 rtl/pipe_buffer_pkg.sv | 18 +
 rtl/pipe_buffer.sv | 77 +++++++
 2 files changed

// File: rtl/pipe_buffer_pkg.sv
// rtl/pipe_buffer_pkg.sv - shared field-size parameters for the fetch/decode stage buffer
package pipe_buffer_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;

    typedef enum logic [1:0] {
        BUF_IDLE  = 2'd0,
        BUF_ENQ   = 2'd1,
        BUF_DEQ   = 2'd2,
        BUF_BOTH  = 2'd3
    } buf_op_t;

    function automatic buf_op_t buf_op(input logic enq, input logic deq);
        return buf_op_t'({deq, enq});
    endfunction

endpackage

// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - small FIFO of {pc,instr} entries between fetch and decode
// Output fields come straight from storage, so there is no combinational input-to-output path.
module pipe_buffer
    import pipe_buffer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_SIZE + 1,
    parameter int INSTR_W = INSTR_SIZE + 1,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + INSTR_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          enq;
    logic          deq;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_pc    = mem[rd_ptr][EW-1:INSTR_W];
    assign out_instr = mem[rd_ptr][INSTR_W-1:0];

    assign enq = in_valid && in_ready && !flush && !reset;
    assign deq = out_valid && out_ready && !stall && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case (buf_op(enq, deq))
                BUF_ENQ: count <= count + 1'b1;
                BUF_DEQ: count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left uncleared by reset and flush.
    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= {in_pc, in_instr};
    end

`ifdef SIMULATE
    always @(posedge clk) begin
        if (!reset && flush)
            $display("%0t PIPEBUF flush pc=%h instr=%h", $time, out_pc, out_instr);
        else if (deq)
            $display("%0t PIPEBUF deq pc=%h instr=%h", $time, out_pc, out_instr);
    end
`endif

endmodule
